power_frame_sink: RTL
=====================

# power_frame_sink

Terminating consumer for the magnitude-squared stream in the FFT peripheral. It accepts 32-bit unsigned power values (|X[k]|², one per FFT bin) over a valid/ready stream and stores one frame in on-chip memory. It tracks the peak bin and then holds the frame for bus-side reads until software acknowledges it. It sits between the squaring stage and the peripheral's register/bus interface.

## Interface
- FRAME_LEN, 256: bins per frame; must equal 2**ADDR_W.
- ADDR_W, 8: bin address width.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_data  in  32  unsigned power value for the current bin.
- i_data_valid  in  1  i_data is valid this cycle.
- o_data_ready  out  1  sink can accept a beat this cycle.
- i_rd_en  in  1  read request.
- i_rd_addr  in  ADDR_W  bin index to read.
- o_rd_data  out  32  stored power value.
- o_rd_valid  out  1  o_rd_data is valid; one-cycle pulse.
- o_frame_done  out  1  a complete frame is held; level signal.
- i_frame_ack  in  1  releases the held frame; one-cycle pulse.
- o_peak_bin  out  ADDR_W  index of the largest value in the last completed frame.
- o_peak_val  out  32  largest value in the last completed frame.
- o_overflow  out  1  sticky flag: a beat was offered while the frame was held.
- o_frame_cnt  out  16  completed frames since reset; wraps at 16 bits.

## Operation
- States:
  - FILL: collecting a frame.
  - HOLD: frame complete; waiting for acknowledge.
- Reset state is FILL.
- o_data_ready is combinational:
  - Equals (state==FILL) && i_rst_n.
  - Not registered.
  - Independent of i_data_valid.
- A beat is accepted on a cycle where i_data_valid && o_data_ready:
  - mem[wr_ptr] <= i_data; wr_ptr increments.
  - Running peak updates if i_data > run_peak (unsigned compare), recording run_bin = wr_ptr.
  - Strictly greater wins, so the lowest bin is kept on ties.
  - The first beat of a frame always loads run_peak/run_bin, including a value of 0.
- When the accepted beat has wr_ptr == FRAME_LEN-1, the next state is HOLD. On the same edge:
  - o_peak_val/o_peak_bin load the final running result, including this last beat.
  - o_frame_cnt increments.
  - wr_ptr wraps to 0.
- In HOLD:
  - o_frame_done = 1 and o_data_ready = 0.
  - Any i_data_valid is dropped and sets o_overflow.
- i_frame_ack while in HOLD:
  - Next state is FILL and o_overflow clears.
  - If a valid beat is dropped in the same cycle, the set takes priority and o_overflow ends at 1.
- i_frame_ack while in FILL is ignored.
- o_peak_val/o_peak_bin hold the last completed frame's values until the next frame completes. They are not cleared by ack.
- Reads are legal in any state:
  - o_rd_data <= mem[i_rd_addr] one cycle after i_rd_en.
  - o_rd_valid pulses on that same cycle.
  - A read during FILL of a bin not yet rewritten returns the previous frame's value.
  - A read and a write to the same address in the same cycle return the old value (read-before-write).
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - o_rd_data = 0, o_rd_valid = 0, o_frame_done = 0.
  - o_peak_bin = 0, o_peak_val = 0.
  - o_overflow = 0, o_frame_cnt = 0.
  - wr_ptr = 0 and the running peak cleared.
- o_data_ready = 0 while i_rst_n = 0.
- o_frame_done rises on the cycle after the last beat is accepted.
- A back-to-back stream at full rate fills a frame in FRAME_LEN cycles.
- o_frame_done falls on the cycle after i_frame_ack. o_data_ready rises combinationally on that same cycle.
- Minimum turnaround from last beat to first beat of the next frame is 2 cycles: one cycle of HOLD with ack asserted.
- Read latency is exactly 1 cycle; back-to-back reads give one result per cycle.
- Reset mid-frame:
  - The partial frame is discarded: wr_ptr = 0, running peak cleared, state FILL.
  - The peak outputs return to 0.

## Test plan
- Bench runs with FRAME_LEN=8, ADDR_W=3.
- Fill: stream 10,20,30,40,50,60,70,80 with valid held high -> o_frame_done rises 1 cycle after the 8th beat; o_peak_bin=7, o_peak_val=80, o_frame_cnt=1, o_data_ready=0.
- Ties and gaps: stream 5,9,9,3,0,9,1,2 with valid toggling 1/0 -> only the 8 valid beats are stored; peak_bin=1, peak_val=9.
- Read-back: in HOLD read addresses 0..7 back-to-back -> o_rd_data matches the written values 1 cycle after each request, and o_rd_valid is high for 8 consecutive cycles.
- Overflow: in HOLD drive valid with 0xDEADBEEF for 3 cycles, then ack -> o_overflow=1 until the ack cycle, then 0; memory is unchanged and the next frame starts at bin 0.
- Ack/drop collision: ack and valid in the same HOLD cycle -> state FILL next cycle, o_overflow=1, and the colliding beat is not stored.
- Reset mid-frame: accept 4 beats, pulse i_rst_n low for 1 cycle, then send 8 beats of 0x100+k -> frame completes after those 8 beats (not 4); peak_bin=7, peak_val=0x107, o_frame_cnt=1.

Source files
------------

// File: rtl/power_frame_sink_if.sv
// Stream and read-bus bundle for power_frame_sink.
// master = producer/reader side, slave = the sink itself.
interface power_frame_sink_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]       data;
  logic              data_valid;
  logic              data_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;

  modport master (
    output data, data_valid, rd_en, rd_addr,
    input  data_ready, rd_data, rd_valid
  );

  modport slave (
    input  data, data_valid, rd_en, rd_addr,
    output data_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/power_frame_sink.sv
// Terminating sink for the |X[k]|^2 stream: stores one frame of power values,
// tracks the peak bin, then holds the frame for bus reads until acknowledged.
module power_frame_sink #(
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  power_frame_sink_if.slave bus,
  output logic              o_frame_done,
  input  logic              i_frame_ack,
  output logic [ADDR_W-1:0] o_peak_bin,
  output logic [31:0]       o_peak_val,
  output logic              o_overflow,
  output logic [15:0]       o_frame_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] run_bin_q, run_bin_d;
  logic [31:0]       run_peak_q, run_peak_d;
  logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
  logic [31:0]       peak_val_q, peak_val_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [31:0]       mem [FRAME_LEN];

  logic              data_ready;
  logic              frame_done;
  logic              accept;
  logic              last_beat;
  logic              drop;
  logic              new_peak;

  // Handshake qualifiers shared by the FSM and the datapath.
  assign accept    = bus.data_valid && data_ready;
  assign last_beat = accept && (wr_ptr_q == ADDR_W'(FRAME_LEN - 1));
  assign drop      = (state_q == HOLD) && bus.data_valid;
  // The first beat of a frame always loads; afterwards only a strictly larger value wins.
  assign new_peak  = (wr_ptr_q == '0) || (bus.data > run_peak_q);

  // State register.
  // NOTE: reset here is synchronous to match the rest of the peripheral, so it sits inside the clocked branch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  // Next-state logic: FILL -> HOLD on the last beat, HOLD -> FILL on ack.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_beat)   state_d = HOLD;
      HOLD:    if (i_frame_ack) state_d = FILL;
      default:                  state_d = FILL;
    endcase
  end

  // FSM outputs: ready is combinational and forced low during reset.
  always_comb begin
    data_ready = (state_q == FILL) && i_rst_n;
    frame_done = (state_q == HOLD);
  end

  // Datapath next-state: write pointer, running/final peak, counters, flags, read port.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    run_peak_d  = run_peak_q;
    run_bin_d   = run_bin_q;
    peak_val_d  = peak_val_q;
    peak_bin_d  = peak_bin_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    rd_valid_d  = bus.rd_en;
    rd_data_d   = rd_data_q;

    if (accept) begin
      // FRAME_LEN == 2**ADDR_W, so the increment wraps to 0 after the last bin.
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (new_peak) begin
        run_peak_d = bus.data;
        run_bin_d  = wr_ptr_q;
      end
    end

    if (last_beat) begin
      peak_val_d  = new_peak ? bus.data : run_peak_q;
      peak_bin_d  = new_peak ? wr_ptr_q : run_bin_q;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Ack clears the sticky flag, but a beat dropped in the same cycle re-sets it.
    if ((state_q == HOLD) && i_frame_ack) overflow_d = 1'b0;
    if (drop)                             overflow_d = 1'b1;

    // Array read happens before this edge's write, giving read-before-write.
    if (bus.rd_en) rd_data_d = mem[bus.rd_addr];
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      run_peak_q  <= '0;
      run_bin_q   <= '0;
      peak_val_q  <= '0;
      peak_bin_q  <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      run_peak_q  <= run_peak_d;
      run_bin_q   <= run_bin_d;
      peak_val_q  <= peak_val_d;
      peak_bin_q  <= peak_bin_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Frame storage write port.
  // NOTE: the memory has no reset; clearing it would need FRAME_LEN cycles or block RAM inference.
  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_ptr_q] <= bus.data;
  end

  assign bus.data_ready = data_ready;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign o_frame_done   = frame_done;
  assign o_peak_bin     = peak_bin_q;
  assign o_peak_val     = peak_val_q;
  assign o_overflow     = overflow_q;
  assign o_frame_cnt    = frame_cnt_q;

endmodule
